// File: rtl/noc_output_port_arbiter_pkg.sv
// Shared types and default sizing for the NoC output-port switch allocator.
package Noc_parameters;

    localparam int Noc_VC_Channel   = 2;
    localparam int NOC_CREDIT_DEPTH = 4;
    localparam int NOC_CREDIT_W     = $clog2(NOC_CREDIT_DEPTH + 1);
    localparam int NOC_VC_W         = $clog2(Noc_VC_Channel);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_output_port_arbiter_rr_arbiter.sv
// Round-robin priority pick among eligible requesters; the pointer moves past
// the previous winner when the top module strobes ptr_update.
module noc_rr_arbiter #(
    parameter int NUM_REQ = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr_update,
    input  logic [NUM_REQ-1:0] winner,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr_q, ptr_d, nxt_s;
    int            best_s;

    function automatic int rr_dist(input int idx, input int ptr);
        return (idx + NUM_REQ - ptr) % NUM_REQ;
    endfunction

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Closest eligible requester at or after the pointer wins
    always_comb begin
        best_s = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            best_s = (req[i] && (rr_dist(i, int'(ptr_q)) < best_s)) ? rr_dist(i, int'(ptr_q)) : best_s;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt[i] = req[i] && (rr_dist(i, int'(ptr_q)) == best_s);
        end
    end

    // Next pointer is one past the released winner
    always_comb begin
        nxt_s = {PW{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            nxt_s = nxt_s | (winner[i] ? PW'((i + 1) % NUM_REQ) : {PW{1'b0}});
        end
        ptr_d = ptr_update ? nxt_s : ptr_q;
    end

endmodule

// File: rtl/noc_output_port_arbiter.sv
// Output-port switch allocator: round-robin wormhole lock plus per-VC credits.
// Optional stall watchdog built when NOC_ARB_WATCHDOG_EN is defined.
module noc_output_port_arbiter
    import Noc_parameters::*;
#(
    parameter int NUM_REQ        = 5,
    parameter int CHANNELS       = Noc_VC_Channel,
    parameter int CREDIT_DEPTH   = NOC_CREDIT_DEPTH,
    parameter int WATCHDOG_LIMIT = 256
) (
    input  logic                                 noc_clk,
    input  logic                                 noc_rst,
    input  logic [NUM_REQ-1:0]                   request,
    input  logic [NUM_REQ-1:0]                   start_of_packet,
    input  logic [NUM_REQ-1:0]                   end_of_packet,
    input  logic [NUM_REQ*$clog2(CHANNELS)-1:0]  req_vc,
    input  logic                                 flit_fire,
    input  logic [CHANNELS-1:0]                  credit_return,
    output logic [NUM_REQ-1:0]                   grant,
    output logic [$clog2(CHANNELS)-1:0]          grant_vc,
    output logic                                 flit_enable,
    output logic [CHANNELS-1:0]                  credit_avail,
    output logic                                 credit_err,
    output logic                                 watchdog_timeout
);

    localparam int VC_W = (CHANNELS == Noc_VC_Channel) ? NOC_VC_W : $clog2(CHANNELS);
    localparam int CW   = (CREDIT_DEPTH == NOC_CREDIT_DEPTH) ? NOC_CREDIT_W : $clog2(CREDIT_DEPTH + 1);

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [VC_W-1:0]     grant_vc_q, grant_vc_d;
    logic [CW-1:0]       cred_q [CHANNELS];
    logic [CW-1:0]       cred_d [CHANNELS];
    logic                flit_enable_q, flit_enable_d;
    logic [CHANNELS-1:0] credit_avail_q, credit_avail_d;
    logic                credit_err_q, credit_err_d;
    logic [NUM_REQ-1:0]  eligible_s, rr_gnt_s;
    logic [VC_W-1:0]     win_vc_s;
    logic                fire_ok_s, release_s, wd_fire_s, leave_s, ovf_s;

    // flit_enable_q already implies LOCKED with credit on grant_vc
    assign fire_ok_s = flit_fire & flit_enable_q;
    assign release_s = (state_q == LOCKED) & fire_ok_s & (|(grant_q & end_of_packet));
    assign leave_s   = release_s | wd_fire_s;

    noc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk        (noc_clk),
        .rst        (noc_rst),
        .req        (eligible_s),
        .ptr_update (leave_s),
        .winner     (grant_q),
        .gnt        (rr_gnt_s)
    );

    // Head-flit eligibility and the winner's target VC
    always_comb begin
        win_vc_s = {VC_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible_s[i] = request[i] & start_of_packet[i] & (cred_q[req_vc[i*VC_W +: VC_W]] != {CW{1'b0}});
            win_vc_s      = win_vc_s | (rr_gnt_s[i] ? req_vc[i*VC_W +: VC_W] : {VC_W{1'b0}});
        end
    end

    // State and output registers
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            state_q        <= IDLE;
            grant_q        <= {NUM_REQ{1'b0}};
            grant_vc_q     <= {VC_W{1'b0}};
            flit_enable_q  <= 1'b0;
            credit_avail_q <= {CHANNELS{1'b1}};
            credit_err_q   <= 1'b0;
            for (int v = 0; v < CHANNELS; v++) begin
                cred_q[v] <= CW'(CREDIT_DEPTH);
            end
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            grant_vc_q     <= grant_vc_d;
            flit_enable_q  <= flit_enable_d;
            credit_avail_q <= credit_avail_d;
            credit_err_q   <= credit_err_d;
            for (int v = 0; v < CHANNELS; v++) begin
                cred_q[v] <= cred_d[v];
            end
        end
    end

    // Next-state logic
    always_comb begin
        case (state_q)
            IDLE:    state_d = (|eligible_s) ? LOCKED : IDLE;
            LOCKED:  state_d = leave_s ? IDLE : LOCKED;
            default: state_d = IDLE;
        endcase
    end

    // Grant and enable outputs
    always_comb begin
        grant_d    = {NUM_REQ{1'b0}};
        grant_vc_d = grant_vc_q;
        case (state_q)
            IDLE: begin
                if (|eligible_s) begin
                    grant_d    = rr_gnt_s;
                    grant_vc_d = win_vc_s;
                end else begin
                    grant_d    = {NUM_REQ{1'b0}};
                end
            end
            LOCKED: begin
                if (leave_s) begin
                    grant_d = {NUM_REQ{1'b0}};
                end else begin
                    grant_d = grant_q;
                end
            end
            default: begin
                grant_d    = {NUM_REQ{1'b0}};
                grant_vc_d = {VC_W{1'b0}};
            end
        endcase
        flit_enable_d = (state_d == LOCKED) && (cred_d[grant_vc_d] != {CW{1'b0}});
        credit_err_d  = credit_err_q | (flit_fire & ~flit_enable_q) | ovf_s;
    end

    // Credit counters; a fire and a return on the same VC cancel out
    always_comb begin
        ovf_s = 1'b0;
        for (int v = 0; v < CHANNELS; v++) begin
            if (credit_return[v] && !(fire_ok_s && (grant_vc_q == VC_W'(v)))) begin
                if (cred_q[v] == CW'(CREDIT_DEPTH)) begin
                    cred_d[v] = cred_q[v];
                    ovf_s     = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + CW'(1);
                end
            end else if (!credit_return[v] && fire_ok_s && (grant_vc_q == VC_W'(v))) begin
                cred_d[v] = cred_q[v] - CW'(1);
            end else begin
                cred_d[v] = cred_q[v];
            end
            credit_avail_d[v] = (cred_d[v] != {CW{1'b0}});
        end
    end

`ifdef NOC_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WATCHDOG_LIMIT + 1);

    logic [WW-1:0] stall_q, stall_d;
    logic          wdt_q, wdt_d;

    // Stall counter: the LIMIT-th cycle without a counted fire forces release
    always_comb begin
        wd_fire_s = (state_q == LOCKED) && !fire_ok_s && (stall_q == WW'(WATCHDOG_LIMIT - 1));
        if ((state_q == LOCKED) && !fire_ok_s && !wd_fire_s) begin
            stall_d = stall_q + WW'(1);
        end else begin
            stall_d = {WW{1'b0}};
        end
        wdt_d = wdt_q | wd_fire_s;
    end

    // Watchdog registers
    always_ff @(posedge noc_clk or posedge noc_rst) begin
        if (noc_rst) begin
            stall_q <= {WW{1'b0}};
            wdt_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            wdt_q   <= wdt_d;
        end
    end

    assign watchdog_timeout = wdt_q;
`else
    assign wd_fire_s        = 1'b0;
    assign watchdog_timeout = 1'b0;
`endif

    assign grant        = grant_q;
    assign grant_vc     = grant_vc_q;
    assign flit_enable  = flit_enable_q;
    assign credit_avail = credit_avail_q;
    assign credit_err   = credit_err_q;

endmodule
